// File: rtl/imm_gen_pipe.sv
// Two-stage elastic RV32/RV64 immediate generator: S1 decodes the format, S2 extends the immediate.
// Optional macro IMMGEN_CSR_EN enables the Z (CSR uimm) format for SYSTEM funct3[2]=1.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illeg,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_SHAMT = 3'd1;
  localparam logic [2:0] FMT_B     = 3'd2;
  localparam logic [2:0] FMT_J     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_S     = 3'd5;
  localparam logic [2:0] FMT_Z     = 3'd6;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Gathers the scattered immediate bits into a signed 32-bit value, then widens to XLEN.
  function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] ins, input logic [2:0] fmt,
                                              input logic w32);
    logic signed [31:0] raw;
    logic [5:0]         shamt;
    raw     = '0;
    shamt   = (XLEN == 64 && !w32) ? ins[25:20] : {1'b0, ins[24:20]};
    ext_imm = '0;
    case (fmt)
      FMT_I:   raw = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_J:   raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_U:   raw = {ins[31:12], 12'b0};
      default: raw = '0;
    endcase
    case (fmt)
      FMT_SHAMT: ext_imm = XLEN'(shamt);
      FMT_Z:     ext_imm = XLEN'(ins[19:15]);
      default:   ext_imm = XLEN'(raw);
    endcase
  endfunction

  logic [2:0]       dec_fmt;
  logic             dec_illeg;
  logic             dec_w32;

  logic             s2_ready;
  logic             ld_p1;
  logic             ld_p2;

  logic             vld_p1_d,   vld_p1_q;
  logic [31:0]      instr_p1_d, instr_p1_q;
  logic [TAG_W-1:0] tag_p1_d,   tag_p1_q;
  logic [2:0]       fmt_p1_d,   fmt_p1_q;
  logic             illeg_p1_d, illeg_p1_q;
  logic             w32_p1_d,   w32_p1_q;

  logic             vld_p2_d,   vld_p2_q;
  logic [XLEN-1:0]  imm_p2_d,   imm_p2_q;
  logic [2:0]       fmt_p2_d,   fmt_p2_q;
  logic             illeg_p2_d, illeg_p2_q;
  logic [TAG_W-1:0] tag_p2_d,   tag_p2_q;

  always_comb begin
    dec_fmt   = FMT_NONE;
    dec_illeg = 1'b0;
    dec_w32   = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illeg = 1'b1;
    end else begin
      case (in_instr[6:0])
        OPC_OP_IMM: dec_fmt = (in_instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
        OPC_LOAD, OPC_JALR, OPC_FENCE: dec_fmt = FMT_I;
        OPC_STORE:  dec_fmt = FMT_S;
        OPC_BRANCH: dec_fmt = FMT_B;
        OPC_JAL:    dec_fmt = FMT_J;
        OPC_LUI, OPC_AUIPC: dec_fmt = FMT_U;
        OPC_OP:     dec_fmt = FMT_NONE;
        OPC_SYSTEM: begin
`ifdef IMMGEN_CSR_EN
          if (in_instr[14]) dec_fmt = FMT_Z;
`endif
        end
        OPC_OP_IMM32: begin
          if (XLEN == 64) begin
            dec_fmt = (in_instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
            dec_w32 = 1'b1;
          end else begin
            dec_illeg = 1'b1;
          end
        end
        default: dec_illeg = 1'b1;
      endcase
    end
  end

  always_comb begin
    s2_ready = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || s2_ready;
    ld_p1    = in_valid && in_ready;
    ld_p2    = vld_p1_q && s2_ready;

    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (in_ready) vld_p1_d = in_valid;
    if (s2_ready) vld_p2_d = vld_p1_q;
    if (flush_i) begin
      vld_p1_d = 1'b0;
      vld_p2_d = 1'b0;
    end

    // Stage 1: raw instruction, tag and decoded format
    instr_p1_d = ld_p1 ? in_instr  : instr_p1_q;
    tag_p1_d   = ld_p1 ? in_tag    : tag_p1_q;
    fmt_p1_d   = ld_p1 ? dec_fmt   : fmt_p1_q;
    illeg_p1_d = ld_p1 ? dec_illeg : illeg_p1_q;
    w32_p1_d   = ld_p1 ? dec_w32   : w32_p1_q;

    // Stage 2: extended immediate presented at the outputs
    imm_p2_d   = ld_p2 ? ext_imm(instr_p1_q, fmt_p1_q, w32_p1_q) : imm_p2_q;
    fmt_p2_d   = ld_p2 ? fmt_p1_q   : fmt_p2_q;
    illeg_p2_d = ld_p2 ? illeg_p1_q : illeg_p2_q;
    tag_p2_d   = ld_p2 ? tag_p1_q   : tag_p2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      imm_p2_q   <= '0;
      fmt_p2_q   <= FMT_NONE;
      illeg_p2_q <= 1'b0;
      tag_p2_q   <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      imm_p2_q   <= imm_p2_d;
      fmt_p2_q   <= fmt_p2_d;
      illeg_p2_q <= illeg_p2_d;
      tag_p2_q   <= tag_p2_d;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    instr_p1_q <= instr_p1_d;
    tag_p1_q   <= tag_p1_d;
    fmt_p1_q   <= fmt_p1_d;
    illeg_p1_q <= illeg_p1_d;
    w32_p1_q   <= w32_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_imm   = imm_p2_q;
  assign out_fmt   = fmt_p2_q;
  assign out_illeg = illeg_p2_q;
  assign out_tag   = tag_p2_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vector table, stall/flush/reset sequences, and
// randomized traffic scored against an arithmetic reference model.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int NV    = 15;
  localparam logic [6:0] OPS [13] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h23, 7'h63, 7'h6F,
                                      7'h37, 7'h17, 7'h33, 7'h73, 7'h1B, 7'h2B};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush_i = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illeg;
  logic [TAG_W-1:0] out_tag;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illeg(out_illeg), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        il;
  } vec_t;

  typedef struct {
    logic [63:0]      imm;
    logic [2:0]       fmt;
    logic             il;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] tr(input logic [63:0] x);
    return (XLEN == 64) ? x : {32'd0, x[31:0]};
  endfunction

  // Reference: immediate assembled arithmetically from the field layout of each format.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t   e;
    int     si;
    longint s;
    longint u;
    int     f3;
    si = int'(ins);
    s  = si;
    u  = longint'({32'd0, ins});
    f3 = int'(ins[14:12]);
    e.imm = '0; e.fmt = 3'd7; e.il = 1'b0; e.tag = '0; e.acc = 0;
    if (ins[1:0] != 2'b11) e.il = 1'b1;
    else begin
      case (ins[6:0])
        7'h13, 7'h1B: begin
          if (ins[6:0] == 7'h1B && XLEN == 32) e.il = 1'b1;
          else if (f3 == 1 || f3 == 5) begin
            e.fmt = 3'd1;
            e.imm = (u >> 20) & ((XLEN == 64 && ins[6:0] == 7'h13) ? 64'd63 : 64'd31);
          end else begin
            e.fmt = 3'd0; e.imm = s >>> 20;
          end
        end
        7'h03, 7'h67, 7'h0F: begin e.fmt = 3'd0; e.imm = s >>> 20; end
        7'h23: begin e.fmt = 3'd5; e.imm = (s >>> 25) * 32 + ((u >> 7) & 31); end
        7'h63: begin
          e.fmt = 3'd2;
          e.imm = (s >>> 31) * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
        end
        7'h6F: begin
          e.fmt = 3'd3;
          e.imm = (s >>> 31) * 1048576 + ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048
                  + ((u >> 21) & 1023) * 2;
        end
        7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = (s >>> 12) * 4096; end
        7'h33: e.fmt = 3'd7;
        7'h73: begin
`ifdef IMMGEN_CSR_EN
          if (f3 >= 4) begin e.fmt = 3'd6; e.imm = (u >> 15) & 31; end
`endif
        end
        default: e.il = 1'b1;
      endcase
    end
    e.imm = tr(e.imm);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = OPS[$urandom_range(0, 12)];
    return r;
  endfunction

  vec_t tbl [NV];
  exp_t q[$];
  exp_t e;

  initial begin
    tbl[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0};
    tbl[1]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
    tbl[2]  = '{32'h0010006F, 64'h0000_0000_0000_0800, 3'd3, 1'b0};
    tbl[3]  = '{32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0};
    tbl[4]  = '{32'h00500093, 64'h5, 3'd0, 1'b0};
    tbl[5]  = '{32'h40505013, 64'h5, 3'd1, 1'b0};
    tbl[6]  = '{32'h00000000, 64'h0, 3'd7, 1'b1};
    tbl[7]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
`ifdef IMMGEN_CSR_EN
    tbl[8]  = '{32'h3401D073, 64'h3, 3'd6, 1'b0};
`else
    tbl[8]  = '{32'h3401D073, 64'h0, 3'd7, 1'b0};
`endif
    tbl[9]  = '{32'hFE112C23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 1'b0};
    tbl[10] = '{32'h002081B3, 64'h0, 3'd7, 1'b0};
    if (XLEN == 64) tbl[11] = '{32'h01F0909B, 64'd31, 3'd1, 1'b0};
    else            tbl[11] = '{32'h01F0909B, 64'h0, 3'd7, 1'b1};
    tbl[12] = '{32'hFFF00090, 64'h0, 3'd7, 1'b1};
    tbl[13] = '{32'h7FF08067, 64'h7FF, 3'd0, 1'b0};
    if (XLEN == 64) tbl[14] = '{32'h43F0D093, 64'd63, 3'd1, 1'b0};
    else            tbl[14] = '{32'h43F0D093, 64'd31, 3'd1, 1'b0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_fmt", out_fmt, 3'd7);
    chk("rst_out_illeg", out_illeg, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // Back-to-back table, each result due two cycles after its accept
    out_ready = 1'b1;
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("tbl_valid", out_valid, 1);
        chk($sformatf("tbl%0d_imm", i - 2), out_imm, tr(tbl[i-2].imm));
        chk($sformatf("tbl%0d_fmt", i - 2), out_fmt, tbl[i-2].fmt);
        chk($sformatf("tbl%0d_illeg", i - 2), out_illeg, tbl[i-2].il);
        chk($sformatf("tbl%0d_tag", i - 2), out_tag, 64'(i - 2));
      end
      if (i < NV) begin
        in_valid = 1'b1; in_instr = tbl[i].instr; in_tag = TAG_W'(i);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("tbl_drained", out_valid, 0);

    // Stall: two accepts fill the pipe, third waits until out_ready returns
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 5'd1;
    #1 chk("stall_rdy_a", in_ready, 1);
    @(negedge clk); in_instr = 32'h00200093; in_tag = 5'd2;
    #1 chk("stall_rdy_b", in_ready, 1);
    @(negedge clk); in_instr = 32'h00300093; in_tag = 5'd3;
    #1 chk("stall_rdy_c", in_ready, 0);
    chk("stall_valid_c", out_valid, 1);
    chk("stall_imm_c", out_imm, 1);
    @(negedge clk);
    #1 chk("stall_rdy_d", in_ready, 0);
    chk("stall_hold_tag", out_tag, 1);
    chk("stall_hold_imm", out_imm, 1);
    out_ready = 1'b1;
    #1 chk("stall_rdy_release", in_ready, 1);
    @(negedge clk); in_valid = 1'b0;
    chk("stall_tag2", out_tag, 2);
    chk("stall_imm2", out_imm, 2);
    @(negedge clk);
    chk("stall_tag3", out_tag, 3);
    chk("stall_imm3", out_imm, 3);
    @(negedge clk);
    chk("stall_empty", out_valid, 0);

    // Flush with the pipe full and a simultaneous input
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00400093; in_tag = 5'd4;
    @(negedge clk); in_tag = 5'd5;
    @(negedge clk); in_tag = 5'd6; flush_i = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    chk("flush_valid_before", out_valid, 1);
    @(negedge clk); flush_i = 1'b0; in_valid = 1'b0;
    chk("flush_valid_after", out_valid, 0);
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("flush_no_leak", out_valid, 0);
    end

    // Randomized traffic against the model
    q.delete();
    for (int c = 0; c < 460; c++) begin
      @(negedge clk);
      in_valid  = (c < 400) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 400) || ($urandom_range(0, 2) != 0);
      in_instr  = rand_instr();
      in_tag    = TAG_W'($urandom);
      #1;
      chk("rnd_out_valid", out_valid, (q.size() > 0 && (c - q[0].acc) >= 2));
      chk("rnd_in_ready", in_ready, (q.size() < 2 || out_ready));
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rnd_imm", out_imm, e.imm);
        chk("rnd_fmt", out_fmt, e.fmt);
        chk("rnd_illeg", out_illeg, e.il);
        chk("rnd_tag", out_tag, e.tag);
      end
      if (in_valid && in_ready) begin
        e = model(in_instr);
        e.tag = in_tag;
        e.acc = c;
        q.push_back(e);
      end
    end
    chk("rnd_drained", q.size(), 0);

    // Asynchronous reset mid-stream
    @(negedge clk); in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 5'd9; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_valid_before", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_imm", out_imm, 0);
    chk("arst_fmt", out_fmt, 3'd7);
    chk("arst_tag", out_tag, 0);
    chk("arst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
